// File: rtl/clmul_kpipe.sv
// Pipelined Karatsuba carryless multiplier over GF(2)[x] with valid/ready handshake,
// sideband tag, and optional reduction modulo x^W + POLY.
module clmul_kpipe #(
    parameter int unsigned  W      = 16,
    parameter int unsigned  TAG_W  = 4,
    parameter int unsigned  REDUCE = 0,
    parameter logic [W-1:0] POLY   = 'h2B
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_x,
    input  logic [W-1:0]     in_y,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   out_z,
    output logic [TAG_W-1:0] out_tag
);

    if ((W < 4) || ((W & (W - 1)) != 0)) begin : g_bad_w
        $fatal(1, "clmul_kpipe: W must be a power of two and at least 4");
    end

    localparam int unsigned LEVELS = $clog2(W / 4);
    localparam int unsigned STAGES = 2 + LEVELS + ((REDUCE != 0) ? 1 : 0);
    localparam int unsigned NLEAF  = 3 ** LEVELS;

    // Bit offset of tree level lvl in a flat bus holding 3^m nodes of width W>>m per level m.
    function automatic int unsigned op_off(input int unsigned lvl);
        int unsigned s;
        int unsigned n;
        s = 0;
        n = 1;
        for (int unsigned m = 0; m < lvl; m++) begin
            s = s + n * (W >> m);
            n = n * 3;
        end
        return s;
    endfunction

    localparam int unsigned PR_TOT   = 2 * op_off(LEVELS + 1);
    localparam int unsigned LEAF_OFF = 2 * op_off(LEVELS);

    function automatic logic [7:0] clmul4(input logic [3:0] a, input logic [3:0] b);
        logic [7:0] r;
        r = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (b[i]) r = r ^ ({4'b0, a} << i);
        end
        return r;
    endfunction

    // Leaf operand for node idx: base-3 digits of idx, most significant first, pick lo/hi/lo^hi
    // at each split level, matching child order 3j, 3j+1, 3j+2 used by the combine tree.
    function automatic logic [3:0] leaf_op(input logic [W-1:0] v_in, input int unsigned idx);
        logic [W-1:0] v;
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic [W-1:0] mask;
        int unsigned  w;
        int unsigned  p3;
        v  = v_in;
        w  = W;
        p3 = NLEAF / 3;
        for (int unsigned m = 0; m < LEVELS; m++) begin
            mask = {W{1'b1}} >> (W - w / 2);
            lo   = v & mask;
            hi   = (v >> (w / 2)) & mask;
            case ((idx / p3) % 3)
                0:       v = lo;
                1:       v = hi;
                default: v = lo ^ hi;
            endcase
            w  = w / 2;
            p3 = p3 / 3;
        end
        return v[3:0];
    endfunction

    function automatic logic [W-1:0] fold(input logic [2*W-1:0] p_in);
        logic [2*W-1:0] p;
        logic [2*W-1:0] poly_ext;
        p        = p_in;
        poly_ext = {{W{1'b0}}, POLY};
        for (int unsigned i = 2 * W - 1; i >= W; i--) begin
            if (p[i]) begin
                p    = p ^ (poly_ext << (i - W));
                p[i] = 1'b0;
            end
        end
        return p[W-1:0];
    endfunction

    logic             adv;
    logic [W-1:0]     x_q;
    logic [W-1:0]     y_q;
    logic [PR_TOT-1:0] p_d;
    logic [PR_TOT-1:0] p_q;
    logic             vld_q [STAGES];
    logic [TAG_W-1:0] tag_q [STAGES];

    assign out_valid = vld_q[STAGES-1];
    assign out_tag   = tag_q[STAGES-1];
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;

    for (genvar j = 0; j < NLEAF; j++) begin : g_leaf
        assign p_d[LEAF_OFF + 8*j +: 8] = clmul4(leaf_op(x_q, j), leaf_op(y_q, j));
    end

    // Level l slice of p_q is built from level l+1 slice, so each level sits one stage later.
    for (genvar l = 0; l < LEVELS; l++) begin : g_comb
        localparam int unsigned WL = W >> l;
        localparam int unsigned H  = WL / 2;
        localparam int unsigned NL = 3 ** l;
        localparam int unsigned OA = 2 * op_off(l);
        localparam int unsigned OB = 2 * op_off(l + 1);
        for (genvar j = 0; j < NL; j++) begin : g_node
            logic [WL-1:0] z1;
            logic [WL-1:0] z2;
            logic [WL-1:0] z3;
            assign z1 = p_q[OB + (3*j)     * WL +: WL];
            assign z2 = p_q[OB + (3*j + 1) * WL +: WL];
            assign z3 = p_q[OB + (3*j + 2) * WL +: WL];
            assign p_d[OA + j * 2 * WL +: 2 * WL] =
                {z2, z1} ^ ({{WL{1'b0}}, z1 ^ z2 ^ z3} << H);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q <= '0;
            y_q <= '0;
            p_q <= '0;
            for (int unsigned i = 0; i < STAGES; i++) begin
                vld_q[i] <= 1'b0;
                tag_q[i] <= '0;
            end
        end else if (adv) begin
            x_q      <= in_x;
            y_q      <= in_y;
            p_q      <= p_d;
            vld_q[0] <= in_valid;
            tag_q[0] <= in_tag;
            for (int unsigned i = 1; i < STAGES; i++) begin
                vld_q[i] <= vld_q[i-1];
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    if (REDUCE != 0) begin : g_red
        logic [W-1:0] red_q;
        always_ff @(posedge clk) begin
            if (rst) begin
                red_q <= '0;
            end else if (adv) begin
                red_q <= fold(p_q[2*W-1:0]);
            end
        end
        assign out_z = {{W{1'b0}}, red_q};
    end else begin : g_full
        assign out_z = p_q[2*W-1:0];
    end

endmodule

// File: tb/tb_clmul_kpipe.sv
// Bench for clmul_kpipe: four configurations run side by side, checked against a
// bit-serial shift-xor model through per-instance result queues.
module tb_clmul_kpipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        iv   [4];
    logic        ir   [4];
    logic        ov   [4];
    logic        ordy [4];
    logic [31:0] ix   [4];
    logic [31:0] iy   [4];
    logic [3:0]  it   [4];
    logic [3:0]  ot   [4];
    logic [63:0] oz   [4];
    logic [15:0] z0;
    logic [15:0] z1;
    logic [31:0] z2;
    logic [63:0] z3;

    localparam int          WV [4] = '{8, 8, 16, 32};
    localparam bit          RV [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    localparam logic [31:0] PV [4] = '{32'h0, 32'h1B, 32'h0, 32'hAF};
    localparam int          LV [4] = '{3, 4, 4, 6};

    localparam logic [31:0] BX [3] = '{32'hFFFF, 32'h8000, 32'h0001};
    localparam logic [31:0] BY [3] = '{32'hFFFF, 32'h8000, 32'h1234};
    localparam logic [63:0] BZ [3] = '{64'h55555555, 64'h40000000, 64'h00001234};

    clmul_kpipe #(.W(8), .TAG_W(4), .REDUCE(0)) u_w8 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
        .in_x(ix[0][7:0]), .in_y(iy[0][7:0]), .in_tag(it[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_z(z0), .out_tag(ot[0]));

    clmul_kpipe #(.W(8), .TAG_W(4), .REDUCE(1), .POLY(8'h1B)) u_w8r (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
        .in_x(ix[1][7:0]), .in_y(iy[1][7:0]), .in_tag(it[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_z(z1), .out_tag(ot[1]));

    clmul_kpipe #(.W(16), .TAG_W(4), .REDUCE(0)) u_w16 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
        .in_x(ix[2][15:0]), .in_y(iy[2][15:0]), .in_tag(it[2]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .out_z(z2), .out_tag(ot[2]));

    clmul_kpipe #(.W(32), .TAG_W(4), .REDUCE(1), .POLY(32'hAF)) u_w32r (
        .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(ir[3]),
        .in_x(ix[3]), .in_y(iy[3]), .in_tag(it[3]),
        .out_valid(ov[3]), .out_ready(ordy[3]), .out_z(z3), .out_tag(ot[3]));

    assign oz[0] = {48'h0, z0};
    assign oz[1] = {48'h0, z1};
    assign oz[2] = {32'h0, z2};
    assign oz[3] = z3;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %h, expected %h at %0t", name, k, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] msk(input int k);
        return (WV[k] == 32) ? 32'hFFFF_FFFF : ((32'h1 << WV[k]) - 32'h1);
    endfunction

    // Textbook definition: xor shifted copies of x, then long division by x^W + POLY.
    function automatic logic [63:0] model(input int k, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] p;
        logic [63:0] pe;
        int w;
        w = WV[k];
        p = '0;
        for (int i = 0; i < w; i++) if (y[i]) p = p ^ ({32'h0, x} << i);
        if (RV[k]) begin
            pe = {32'h0, PV[k]} | (64'h1 << w);
            for (int i = 2 * w - 1; i >= w; i--) if (p[i]) p = p ^ (pe << (i - w));
        end
        return p;
    endfunction

    logic [67:0] sb [4][$];
    logic        hv [4];
    logic [67:0] hd [4];
    logic [67:0] e;

    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (rst) begin
                sb[k].delete();
                hv[k] = 1'b0;
            end else begin
                if (hv[k]) begin
                    chk("hold_valid", k, {63'b0, ov[k]}, 64'd1);
                    chk("hold_z", k, oz[k], hd[k][63:0]);
                    chk("hold_tag", k, {60'b0, ot[k]}, {60'b0, hd[k][67:64]});
                end
                if (ov[k] && ordy[k]) begin
                    if (sb[k].size() == 0) begin
                        chk("spurious_out", k, {63'b0, ov[k]}, 64'd0);
                    end else begin
                        e = sb[k].pop_front();
                        chk("z", k, oz[k], e[63:0]);
                        chk("tag", k, {60'b0, ot[k]}, {60'b0, e[67:64]});
                    end
                end
                hv[k] = ov[k] && !ordy[k];
                hd[k] = {ot[k], oz[k]};
                if (iv[k] && ir[k]) sb[k].push_back({it[k], model(k, ix[k], iy[k])});
            end
        end
    end

    task automatic single(input int k, input logic [31:0] x, input logic [31:0] y,
                          input logic [3:0] tag, input logic [63:0] ez, input int elat);
        int n;
        ix[k] = x;
        iy[k] = y;
        it[k] = tag;
        iv[k] = 1'b1;
        @(posedge clk);
        #1;
        iv[k] = 1'b0;
        n = 1;
        while (!ov[k] && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("latency", k, n, elat);
        chk("dir_z", k, oz[k], ez);
        chk("dir_tag", k, {60'b0, ot[k]}, {60'b0, tag});
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        logic a [4];
        logic [3:0] tg;

        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            iv[k] = 1'b0; ordy[k] = 1'b1; ix[k] = '0; iy[k] = '0; it[k] = '0; a[k] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("rst_valid", k, {63'b0, ov[k]}, 64'd0);
            chk("rst_z", k, oz[k], 64'd0);
            chk("rst_tag", k, {60'b0, ot[k]}, 64'd0);
            chk("rst_ready", k, {63'b0, ir[k]}, 64'd1);
        end

        single(0, 32'h57, 32'h83, 4'd3, 64'h2B79, LV[0]);
        single(1, 32'h57, 32'h83, 4'd5, 64'h00C1, LV[1]);
        single(1, 32'h02, 32'h80, 4'd6, 64'h001B, LV[1]);
        single(3, 32'h2, 32'h8000_0000, 4'd7, 64'hAF, LV[3]);
        single(2, 32'h1234, 32'h1, 4'd9, 64'h1234, LV[2]);

        // back-to-back burst on the 16-bit instance
        idx = 0;
        for (int c = 0; c < 12; c++) begin
            if (c < 3) begin
                iv[2] = 1'b1; ix[2] = BX[c]; iy[2] = BY[c]; it[2] = 4'(c + 1);
            end else begin
                iv[2] = 1'b0;
            end
            @(posedge clk);
            #1;
            if (ov[2]) begin
                if (idx < 3) begin
                    chk("burst_cycle", 2, c + 1, 4 + idx);
                    chk("burst_z", 2, oz[2], BZ[idx]);
                    chk("burst_tag", 2, {60'b0, ot[2]}, idx + 1);
                end
                idx++;
            end
        end
        chk("burst_count", 2, idx, 3);

        // backpressure on the 8-bit instance
        tg = 4'd0;
        ordy[0] = 1'b0;
        iv[0] = 1'b1; ix[0] = 32'h3C; iy[0] = 32'hA5; it[0] = tg;
        for (int c = 0; c < 8; c++) begin
            #3;
            a[0] = iv[0] && ir[0];
            @(posedge clk);
            #1;
            if (a[0]) begin
                tg = tg + 4'd1;
                ix[0] = $urandom & msk(0); iy[0] = $urandom & msk(0); it[0] = tg;
            end
        end
        chk("bp_ready", 0, {63'b0, ir[0]}, 64'd0);
        chk("bp_valid", 0, {63'b0, ov[0]}, 64'd1);
        chk("bp_accepted", 0, {60'b0, tg}, 64'd3);
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("bp_ready_held", 0, {63'b0, ir[0]}, 64'd0);
        end
        iv[0] = 1'b0;
        ordy[0] = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("bp_drain", 0, sb[0].size(), 0);

        // reset with three operations in flight
        for (int c = 0; c < 3; c++) begin
            iv[2] = 1'b1; ix[2] = 32'hBEEF + c; iy[2] = 32'h1357; it[2] = 4'(c + 10);
            @(posedge clk);
            #1;
        end
        iv[2] = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst2_valid", 2, {63'b0, ov[2]}, 64'd0);
        chk("rst2_z", 2, oz[2], 64'd0);
        for (int c = 0; c < LV[2]; c++) begin
            @(posedge clk);
            #1;
            chk("rst2_stale", 2, {63'b0, ov[2]}, 64'd0);
        end

        // random traffic on all instances
        for (int k = 0; k < 4; k++) a[k] = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < 4; k++) begin
                if (!iv[k] || a[k]) begin
                    iv[k] = ($urandom_range(0, 3) != 0);
                    ix[k] = $urandom & msk(k);
                    iy[k] = $urandom & msk(k);
                    it[k] = it[k] + 4'd1;
                end
                ordy[k] = ($urandom_range(0, 3) != 0);
            end
            #3;
            for (int k = 0; k < 4; k++) a[k] = iv[k] && ir[k];
            @(posedge clk);
            #1;
        end
        for (int k = 0; k < 4; k++) begin
            iv[k] = 1'b0;
            ordy[k] = 1'b1;
        end
        repeat (20) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) chk("final_drain", k, sb[k].size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
